regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port (we3/a3/wd3) between two writeback sources: port 0 (load/memory writeback) and port 1 (ALU writeback).
- Each source uses a valid/ready handshake; one write is committed per cycle through a registered output stage.
- Fixed priority goes to port 0, with an aging mechanism that guarantees port 1 a grant after MAX_WAIT denied cycles.
- Writes to x0 are accepted but never reach the register file.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_wb_arbiter_if.sv | 39 +++
 rtl/wait_counter.sv | 41 ++++
 rtl/regfile_wb_arbiter.sv | 100 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and sizing helpers for the register-file writeback arbiter.
package regfile_pkg;

   localparam int REGISTERS_DEFAULT = 32;
   localparam int WIDTH_DEFAULT     = 32;
   localparam int MAX_WAIT_DEFAULT  = 4;
   localparam int REG_ADDR_W        = $clog2(REGISTERS_DEFAULT);

   typedef enum logic {ARB_NORMAL = 1'b0, ARB_AGED = 1'b1} arb_state_t;

   function automatic int cnt_width(input int max_wait);
      return $clog2(max_wait + 1);
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the two writeback request channels and the register-file write port.
interface regfile_wb_arbiter_if
   import regfile_pkg::*;
#(
   parameter int REGISTERS = REGISTERS_DEFAULT,
   parameter int WIDTH     = WIDTH_DEFAULT
);
   localparam int AW = $clog2(REGISTERS);

   logic          req0_valid;
   logic [AW-1:0] req0_addr;
   logic [WIDTH-1:0] req0_data;
   logic          req0_ready;
   logic          req1_valid;
   logic [AW-1:0] req1_addr;
   logic [WIDTH-1:0] req1_data;
   logic          req1_ready;
   logic          we3;
   logic [AW-1:0] a3;
   logic [WIDTH-1:0] wd3;
   logic          x0_drop;

   modport master (
      output req0_valid, req0_addr, req0_data,
      input  req0_ready,
      output req1_valid, req1_addr, req1_data,
      input  req1_ready,
      input  we3, a3, wd3, x0_drop
   );

   modport slave (
      input  req0_valid, req0_addr, req0_data,
      output req0_ready,
      input  req1_valid, req1_addr, req1_data,
      output req1_ready,
      output we3, a3, wd3, x0_drop
   );

endinterface

// File: rtl/wait_counter.sv
// Saturating counter of consecutive denied cycles for the low-priority port.
module wait_counter
   import regfile_pkg::*;
#(
   parameter int MAX_WAIT = MAX_WAIT_DEFAULT,
   localparam int CW = cnt_width(MAX_WAIT)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc_i,
   input  logic          clr_i,
   output logic [CW-1:0] count_o,
   output logic          at_max_o
);

   localparam logic [CW-1:0] MAX_VAL = CW'(MAX_WAIT);

   logic [CW-1:0] count_q, count_d;

   // Clear wins over increment; the count sticks at MAX_VAL rather than wrapping.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != MAX_VAL)) begin
         count_d = count_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o  = count_q;
   assign at_max_o = (count_q == MAX_VAL);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter for the single register-file write port,
// fixed priority to port 0 with aging so port 1 cannot starve.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int REGISTERS = REGISTERS_DEFAULT,
   parameter int WIDTH     = WIDTH_DEFAULT,
   parameter int MAX_WAIT  = MAX_WAIT_DEFAULT
) (
   input logic clk,
   input logic rst,
   regfile_wb_arbiter_if.slave bus
);

   localparam int AW = $clog2(REGISTERS);
   localparam int CW = cnt_width(MAX_WAIT);

   arb_state_t       state_q, state_d;
   logic [CW-1:0]    wait_cnt;
   logic             wait_at_max;
   logic             wait_inc, wait_clr;
   logic             grant0, grant1, transfer;
   logic [AW-1:0]    win_addr;
   logic [WIDTH-1:0] win_data;
   logic             we3_q, x0_drop_q;
   logic [AW-1:0]    a3_q;
   logic [WIDTH-1:0] wd3_q;

   // Readies look only at the valids, the arbiter state and reset.
   assign grant0 = !rst && bus.req0_valid && !(bus.req1_valid && (state_q == ARB_AGED));
   assign grant1 = !rst && bus.req1_valid && (!bus.req0_valid || (state_q == ARB_AGED));
   assign transfer = grant0 || grant1;

   assign wait_inc = bus.req1_valid && !grant1;
   assign wait_clr = !bus.req1_valid || grant1;

   wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait (
      .clk      (clk),
      .rst      (rst),
      .inc_i    (wait_inc),
      .clr_i    (wait_clr),
      .count_o  (wait_cnt),
      .at_max_o (wait_at_max)
   );

   // Age on the edge where the denial count reaches MAX_WAIT.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_NORMAL: begin
            if (wait_inc && ((wait_cnt == CW'(MAX_WAIT - 1)) || wait_at_max)) begin
               state_d = ARB_AGED;
            end
         end
         ARB_AGED: begin
            if (grant1 || !bus.req1_valid) begin
               state_d = ARB_NORMAL;
            end
         end
         default: state_d = ARB_NORMAL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ARB_NORMAL;
      end else begin
         state_q <= state_d;
      end
   end

   assign win_addr = grant1 ? bus.req1_addr : bus.req0_addr;
   assign win_data = grant1 ? bus.req1_data : bus.req0_data;

   // Writes to x0 are consumed here and only surface as x0_drop.
   always_ff @(posedge clk) begin
      if (rst) begin
         we3_q     <= 1'b0;
         x0_drop_q <= 1'b0;
         a3_q      <= '0;
         wd3_q     <= '0;
      end else if (transfer) begin
         we3_q     <= (win_addr != '0);
         x0_drop_q <= (win_addr == '0);
         a3_q      <= win_addr;
         wd3_q     <= win_data;
      end else begin
         we3_q     <= 1'b0;
         x0_drop_q <= 1'b0;
      end
   end

   assign bus.req0_ready = grant0;
   assign bus.req1_ready = grant1;
   assign bus.we3        = we3_q;
   assign bus.x0_drop    = x0_drop_q;
   assign bus.a3         = a3_q;
   assign bus.wd3        = wd3_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter with MAX_WAIT = 4.
module tb_regfile_wb_arbiter;
   import regfile_pkg::*;

   logic clk;
   logic rst;
   int   testCount = 0;
   int   failCount = 0;

   logic [REG_ADDR_W-1:0] p0Addr;
   logic expGrant1 [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
   logic [2:0] expCnt [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};

   regfile_wb_arbiter_if #(.REGISTERS(32), .WIDTH(32)) bus ();

   regfile_wb_arbiter #(.REGISTERS(32), .WIDTH(32), .MAX_WAIT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(input logic v0, input logic [REG_ADDR_W-1:0] a0, input logic [31:0] d0,
                                input logic v1, input logic [REG_ADDR_W-1:0] a1, input logic [31:0] d1);
      bus.req0_valid = v0;
      bus.req0_addr  = a0;
      bus.req0_data  = d0;
      bus.req1_valid = v1;
      bus.req1_addr  = a1;
      bus.req1_data  = d1;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2);
      checkOutput("rst_ready0", 32'(bus.req0_ready), 32'd0);
      checkOutput("rst_ready1", 32'(bus.req1_ready), 32'd0);
      tick();
      tick();
      checkOutput("rst_we3", 32'(bus.we3), 32'd0);
      checkOutput("rst_a3", 32'(bus.a3), 32'd0);
      checkOutput("rst_wd3", bus.wd3, 32'd0);
      checkOutput("rst_x0drop", 32'(bus.x0_drop), 32'd0);
      checkOutput("rst_state", 32'(dut.state_q), 32'(ARB_NORMAL));
      checkOutput("rst_waitcnt", 32'(dut.u_wait.count_q), 32'd0);

      rst = 1'b0;
      applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
      checkOutput("p0_ready0", 32'(bus.req0_ready), 32'd1);
      checkOutput("p0_ready1", 32'(bus.req1_ready), 32'd0);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      checkOutput("p0_we3", 32'(bus.we3), 32'd1);
      checkOutput("p0_a3", 32'(bus.a3), 32'd5);
      checkOutput("p0_wd3", bus.wd3, 32'hDEADBEEF);
      checkOutput("p0_x0drop", 32'(bus.x0_drop), 32'd0);
      tick();
      checkOutput("p0_we3_off", 32'(bus.we3), 32'd0);
      checkOutput("p0_a3_hold", 32'(bus.a3), 32'd5);

      p0Addr = 5'd10;
      for (int c = 0; c < 6; c++) begin
         applyStimulus(1'b1, p0Addr, 32'h100 + 32'(p0Addr), 1'b1, 5'd20, 32'h2000);
         checkOutput($sformatf("age%0d_ready0", c), 32'(bus.req0_ready), expGrant1[c] ? 32'd0 : 32'd1);
         checkOutput($sformatf("age%0d_ready1", c), 32'(bus.req1_ready), expGrant1[c] ? 32'd1 : 32'd0);
         tick();
         checkOutput($sformatf("age%0d_we3", c), 32'(bus.we3), 32'd1);
         checkOutput($sformatf("age%0d_a3", c), 32'(bus.a3), expGrant1[c] ? 32'd20 : 32'(p0Addr));
         checkOutput($sformatf("age%0d_wd3", c), bus.wd3, expGrant1[c] ? 32'h2000 : 32'h100 + 32'(p0Addr));
         checkOutput($sformatf("age%0d_waitcnt", c), 32'(dut.u_wait.count_q), 32'(expCnt[c]));
         if (!expGrant1[c]) p0Addr = p0Addr + 5'd1;
      end
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      tick();

      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234);
      checkOutput("x0_ready1", 32'(bus.req1_ready), 32'd1);
      checkOutput("x0_ready0", 32'(bus.req0_ready), 32'd0);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      checkOutput("x0_we3", 32'(bus.we3), 32'd0);
      checkOutput("x0_drop", 32'(bus.x0_drop), 32'd1);
      checkOutput("x0_wd3", bus.wd3, 32'h1234);
      tick();
      checkOutput("x0_drop_off", 32'(bus.x0_drop), 32'd0);

      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1'b1, 5'(i), 32'h50 + 32'(i), 1'b0, 5'd0, 32'h0);
         checkOutput($sformatf("b2b%0d_ready0", i), 32'(bus.req0_ready), 32'd1);
         tick();
         checkOutput($sformatf("b2b%0d_we3", i), 32'(bus.we3), 32'd1);
         checkOutput($sformatf("b2b%0d_a3", i), 32'(bus.a3), 32'(i));
         checkOutput($sformatf("b2b%0d_wd3", i), bus.wd3, 32'h50 + 32'(i));
      end
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      tick();
      checkOutput("b2b_end_we3", 32'(bus.we3), 32'd0);

      applyStimulus(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0);
      tick();
      checkOutput("inrst_pre_we3", 32'(bus.we3), 32'd1);
      checkOutput("inrst_pre_a3", 32'(bus.a3), 32'd3);
      rst = 1'b1;
      applyStimulus(1'b1, 5'd4, 32'h44, 1'b1, 5'd9, 32'h99);
      checkOutput("inrst_ready0", 32'(bus.req0_ready), 32'd0);
      checkOutput("inrst_ready1", 32'(bus.req1_ready), 32'd0);
      tick();
      checkOutput("inrst_we3", 32'(bus.we3), 32'd0);
      checkOutput("inrst_a3", 32'(bus.a3), 32'd0);
      checkOutput("inrst_state", 32'(dut.state_q), 32'(ARB_NORMAL));
      rst = 1'b0;
      applyStimulus(1'b1, 5'd4, 32'h44, 1'b1, 5'd9, 32'h99);
      checkOutput("postrst_ready0", 32'(bus.req0_ready), 32'd1);
      checkOutput("postrst_ready1", 32'(bus.req1_ready), 32'd0);
      tick();
      checkOutput("postrst_a3", 32'(bus.a3), 32'd4);
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      tick();

      applyStimulus(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB);
      checkOutput("same_ready0", 32'(bus.req0_ready), 32'd1);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hB);
      checkOutput("same1_we3", 32'(bus.we3), 32'd1);
      checkOutput("same1_a3", 32'(bus.a3), 32'd7);
      checkOutput("same1_wd3", bus.wd3, 32'hA);
      checkOutput("same_ready1", 32'(bus.req1_ready), 32'd1);
      tick();
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      checkOutput("same2_we3", 32'(bus.we3), 32'd1);
      checkOutput("same2_a3", 32'(bus.a3), 32'd7);
      checkOutput("same2_wd3", bus.wd3, 32'hB);
      tick();
      checkOutput("same_end_we3", 32'(bus.we3), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
